imm_li_expander: RTL and testbench

IMM_LI_EXPANDER -- requirements
Module: imm_li_expander

---
 rtl/imm_li_expander_pkg.sv | 18 +
 rtl/imm_li_expander_li_split.sv | 17 +
 rtl/imm_li_expander.sv | 89 ++++++++
 tb/tb_imm_li_expander.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/imm_li_expander_pkg.sv
// Shared constants, encoders and FSM state type for the load-immediate expander.
package imm_li_expander_pkg;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [2:0]  F3_ADDI  = 3'b000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, F3_ADDI, rd, OP_IMM};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, OP_LUI};
  endfunction
endpackage

// File: rtl/imm_li_expander_li_split.sv
// Splits a 32-bit constant into LUI/ADDI immediates and decides the sequence length.
module li_split
  import imm_li_expander_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [4:0]  i_rd,
  output logic        o_fits,
  output logic [19:0] o_hi20,
  output logic [11:0] o_lo12,
  output logic        o_need_two
);
  assign o_lo12 = i_value[11:0];
  // Adding 0x800 only carries into bit 12 when bit 11 is set, compensating ADDI's sign extension.
  assign o_hi20 = i_value[31:12] + {19'd0, i_value[11]};
  assign o_fits = (&i_value[31:11]) | ~(|i_value[31:11]);
  assign o_need_two = (i_rd != 5'd0) && !o_fits && (o_lo12 != 12'd0);
endmodule

// File: rtl/imm_li_expander.sv
// Expands a load-immediate request into the shortest RV32I LUI/ADDI sequence.
// Optional LI_EXP_STATS_EN adds a saturating count of accepted output words.
module imm_li_expander
  import imm_li_expander_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
`ifdef LI_EXP_STATS_EN
  , output logic [15:0] stat_count
`endif
);
  state_t      r_state, w_state_nxt;
  logic        r_rdy;
  logic [4:0]  r_rd;
  logic [31:0] r_value;
  logic        w_fits, w_need_two;
  logic [19:0] w_hi20;
  logic [11:0] w_lo12;

  li_split u_split (
    .i_value   (r_value),
    .i_rd      (r_rd),
    .o_fits    (w_fits),
    .o_hi20    (w_hi20),
    .o_lo12    (w_lo12),
    .o_need_two(w_need_two)
  );

  // r_rdy keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_rd    <= 5'd0;
      r_value <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= 1'b1;
      if (in_valid && in_ready) begin
        r_rd    <= in_rd;
        r_value <= in_value;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_instr   = 32'd0;
    case (r_state)
      IDLE: begin
        in_ready = r_rdy;
        if (in_valid && r_rdy) w_state_nxt = EMIT1;
      end
      EMIT1: begin
        out_valid = 1'b1;
        out_last  = !w_need_two;
        if (r_rd == 5'd0)  out_instr = NOP_WORD;
        else if (w_fits)   out_instr = enc_addi(w_lo12, 5'd0, r_rd);
        else               out_instr = enc_lui(w_hi20, r_rd);
        if (out_ready) w_state_nxt = w_need_two ? EMIT2 : IDLE;
      end
      EMIT2: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_instr = enc_addi(w_lo12, r_rd, r_rd);
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef LI_EXP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          stat_count <= 16'd0;
    else if (out_valid && out_ready && stat_count != 16'hFFFF) stat_count <= stat_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_imm_li_expander.sv
// Randomized self-checking bench for imm_li_expander against a value-level reference model.
module tb_imm_li_expander;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_value = 32'd0;
  logic        in_ready, out_valid, out_last;
  logic [31:0] out_instr;
`ifdef LI_EXP_STATS_EN
  logic [15:0] stat_count;
`endif

  int total = 0, bad = 0, words = 0;
  logic [31:0] exp_q[$];

  imm_li_expander dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last)
`ifdef LI_EXP_STATS_EN
    , .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addi(input logic [31:0] imm, input logic [31:0] rs1,
                                       input logic [31:0] rd);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
  endfunction

  // Reference: shortest sequence from signed-range arithmetic.
  function automatic void model(input logic [31:0] rd, input logic [31:0] v);
    logic [31:0] hi;
    exp_q.delete();
    if (rd == 0) exp_q.push_back(32'h13);
    else if ($signed(v) >= -2048 && $signed(v) <= 2047) exp_q.push_back(addi(v, 0, rd));
    else begin
      hi = (v + 32'h800) >> 12;
      exp_q.push_back((hi << 12) | (rd << 7) | 32'h37);
      if (v % 4096 != 0) exp_q.push_back(addi(v, rd, rd));
    end
  endfunction

  task automatic run_req(input logic [4:0] rd, input logic [31:0] v, input bit rnd, input int stall);
    int n, idx, cyc, st;
    n = exp_q.size(); idx = 0; cyc = 0; st = stall;
    @(negedge clk);
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("in_ready", {31'd0, in_ready}, 1);
    in_valid = 1'b1; in_rd = rd; in_value = v; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_rd = 5'($urandom); in_value = $urandom;
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("busy_ready", {31'd0, in_ready}, 0);
    cyc = 0;
    while (idx < n && cyc < 200) begin
      @(negedge clk); cyc++;
      chk("valid", {31'd0, out_valid}, 1);
      chk($sformatf("word%0d rd=%0d v=%h", idx, rd, v), out_instr, exp_q[idx]);
      chk("last", {31'd0, out_last}, {31'd0, idx == n - 1});
      if (st > 0) begin out_ready = 1'b0; st--; end
      else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (out_ready) begin idx++; words++; end
    end
    chk("done", idx, n);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_valid", {31'd0, out_valid}, 0);
    chk("idle_ready", {31'd0, in_ready}, 1);
  endtask

  initial begin
    logic [31:0] v, bnd[7];
    logic [4:0]  rd;
    int cyc;
    bnd = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'h7FFFF800, 32'h80000000, 32'hFFFFFFFF};
    #12;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 1);

    exp_q = '{32'h00500093};                run_req(5'd1, 32'd5, 0, 0);
    exp_q = '{32'hFFF00113};                run_req(5'd2, 32'hFFFFFFFF, 0, 0);
    exp_q = '{32'h123451B7, 32'h67818193};  run_req(5'd3, 32'h12345678, 0, 0);
    exp_q = '{32'h000022B7, 32'h80028293};  run_req(5'd5, 32'h00001800, 0, 0);
    exp_q = '{32'h00010237};                run_req(5'd4, 32'h00010000, 0, 0);
    exp_q = '{32'h00000013};                run_req(5'd0, 32'h12345678, 0, 0);
    exp_q = '{32'h123451B7, 32'h67818193};  run_req(5'd3, 32'h12345678, 0, 5);

    // Reset while the first word of a two-word sequence is pending.
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    in_valid = 1'b1; in_rd = 5'd3; in_value = 32'h12345678; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_emit1", {31'd0, out_valid}, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_instr", out_instr, 0);
    chk("mid_rst_last", {31'd0, out_last}, 0);
    chk("mid_rst_ready", {31'd0, in_ready}, 0);
    words = 0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_trail", {31'd0, out_valid}, 0);
    end
    chk("post_rst_ready", {31'd0, in_ready}, 1);
    out_ready = 1'b0;

    for (int i = 0; i < 300; i++) begin
      rd = (i % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 4095)) - 32'd2048;
        2:       v = $urandom & 32'hFFFFF000;
        default: v = bnd[$urandom_range(0, 6)];
      endcase
      model({27'd0, rd}, v);
      run_req(rd, v, 1, 0);
    end

`ifdef LI_EXP_STATS_EN
    chk("stat_count", {16'd0, stat_count}, words);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
